// File: rtl/tt_sweep_ctrl.sv
// Truth-table sweep controller: walks {w,x,y,z} through 0..15, samples f_in after a settle
// time and compares the captured table against EXPECTED. Optional macro TT_SWEEP_SINGLE_STEP_EN adds a step input.
module tt_sweep_ctrl #(
  parameter int          SETTLE_CYCLES = 2,
  parameter logic [15:0] EXPECTED      = 16'h1F55
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
`ifdef TT_SWEEP_SINGLE_STEP_EN
  input  logic        step,
`endif
  input  logic        f_in,
  output logic        w,
  output logic        x,
  output logic        y,
  output logic        z,
  output logic        busy,
  output logic        done,
  output logic [15:0] truth_table,
  output logic        pass,
  output logic [4:0]  mismatch_cnt,
  output logic [3:0]  first_fail_idx,
  output logic        first_fail_valid
);

  localparam logic [3:0] HOLD_LAST = 4'(SETTLE_CYCLES);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  logic [3:0]  idx;
  logic [3:0]  cnt;
  logic        hold_done;
  logic        sample_go;
  logic        accept;
  logic        miss;
  logic [15:0] tt_next;

  function automatic logic [4:0] sat_inc(input logic [4:0] v);
    return (v == 5'd16) ? v : v + 5'd1;
  endfunction

  assign hold_done = (cnt == HOLD_LAST);
`ifdef TT_SWEEP_SINGLE_STEP_EN
  assign sample_go = hold_done && step;
`else
  assign sample_go = hold_done;
`endif
  assign accept = ((state == IDLE) || (state == DONE)) && start && !abort;
  assign miss   = (f_in != EXPECTED[idx]);
  assign {w, x, y, z} = idx;

  always_comb begin
    tt_next      = truth_table;
    tt_next[idx] = f_in;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= IDLE;
      idx              <= 4'd0;
      cnt              <= 4'd0;
      busy             <= 1'b0;
      done             <= 1'b0;
      truth_table      <= 16'd0;
      pass             <= 1'b0;
      mismatch_cnt     <= 5'd0;
      first_fail_idx   <= 4'd0;
      first_fail_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        state            <= RUN;
        busy             <= 1'b1;
        idx              <= 4'd0;
        cnt              <= 4'd0;
        truth_table      <= 16'd0;
        pass             <= 1'b0;
        mismatch_cnt     <= 5'd0;
        first_fail_idx   <= 4'd0;
        first_fail_valid <= 1'b0;
      end else begin
        case (state)
          RUN: begin
            if (abort) begin
              // partial results stay visible; only the sequencing state is dropped
              state <= IDLE;
              busy  <= 1'b0;
              idx   <= 4'd0;
              cnt   <= 4'd0;
            end else if (sample_go) begin
              truth_table <= tt_next;
              cnt         <= 4'd0;
              if (miss) begin
                mismatch_cnt <= sat_inc(mismatch_cnt);
                if (!first_fail_valid) begin
                  first_fail_idx   <= idx;
                  first_fail_valid <= 1'b1;
                end
              end
              if (idx == 4'd15) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
                pass  <= (tt_next == EXPECTED);
                idx   <= 4'd0;
              end else begin
                idx <= idx + 4'd1;
              end
            end else if (!hold_done) begin
              cnt <= cnt + 4'd1;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Directed bench for tt_sweep_ctrl: table of full sweeps against a modelled function block,
// plus hand-written abort, re-start and mid-sweep reset sequences.
module tb_tt_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, start, abort, f_in;
  logic        w, x, y, z, busy, done, pass, first_fail_valid;
  logic [15:0] truth_table;
  logic [4:0]  mismatch_cnt;
  logic [3:0]  first_fail_idx;
`ifdef TT_SWEEP_SINGLE_STEP_EN
  logic        step = 1'b1;
`endif

  int checks = 0;
  int errors = 0;
  int mode   = 0;

  always #5 clk = ~clk;

  tt_sweep_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
`ifdef TT_SWEEP_SINGLE_STEP_EN
    .step(step),
`endif
    .f_in(f_in), .w(w), .x(x), .y(y), .z(z), .busy(busy), .done(done),
    .truth_table(truth_table), .pass(pass), .mismatch_cnt(mismatch_cnt),
    .first_fail_idx(first_fail_idx), .first_fail_valid(first_fail_valid)
  );

  // Function block model: wx' + y'z' + w'z', truth table 16'h1F55
  logic fg;
  always_comb begin
    fg = (w & ~x) | (~y & ~z) | (~w & ~z);
    case (mode)
      0:       f_in = fg;
      1:       f_in = 1'b0;
      2:       f_in = ({w, x, y, z} == 4'd14) ? 1'b1 : fg;
      default: f_in = 1'b1;
    endcase
  end

  typedef struct {
    int          m;
    logic [15:0] tt;
    int          cnt;
    int          ffi;
    int          ffv;
    int          ps;
  } vec_t;

  vec_t tbl[4];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a sweep, optionally re-pulses start at cycle pulse_at, and returns in the done cycle.
  task automatic do_sweep(input int m, input int pulse_at);
    int cyc;
    int vec_err;
    mode  = m;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_rise", int'(busy), 1);
    check("start_clear_tt", int'(truth_table), 0);
    check("start_clear_pass", int'(pass), 0);
    cyc     = 0;
    vec_err = 0;
    while (!done && cyc < 200) begin
      if ({w, x, y, z} != 4'(cyc / 3)) vec_err++;
      if (busy !== 1'b1) vec_err++;
      start = (cyc == pulse_at);
      tick();
      cyc++;
    end
    start = 1'b0;
    check("latency", cyc, 48);
    check("vec_seq", vec_err, 0);
    check("done_busy", int'(busy), 0);
    check("done_vec", int'({w, x, y, z}), 0);
  endtask

  task automatic check_results(input vec_t v);
    check("truth_table", int'(truth_table), int'(v.tt));
    check("mismatch_cnt", int'(mismatch_cnt), v.cnt);
    check("first_fail_idx", int'(first_fail_idx), v.ffi);
    check("first_fail_valid", int'(first_fail_valid), v.ffv);
    check("pass", int'(pass), v.ps);
  endtask

  initial begin
    int seen;
    tbl[0] = '{m: 0, tt: 16'h1F55, cnt: 0, ffi: 0,  ffv: 0, ps: 1};
    tbl[1] = '{m: 1, tt: 16'h0000, cnt: 9, ffi: 0,  ffv: 1, ps: 0};
    tbl[2] = '{m: 2, tt: 16'h5F55, cnt: 1, ffi: 14, ffv: 1, ps: 0};
    tbl[3] = '{m: 3, tt: 16'hFFFF, cnt: 7, ffi: 1,  ffv: 1, ps: 0};

    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    repeat (3) tick();
    check("rst_busy_done", int'({busy, done}), 0);
    check("rst_vec", int'({w, x, y, z}), 0);
    check("rst_results", int'({pass, first_fail_valid, first_fail_idx, mismatch_cnt}), 0);
    check("rst_tt", int'(truth_table), 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) begin
      do_sweep(tbl[i].m, -1);
      check_results(tbl[i]);
      tick();
      check("done_pulse_end", int'(done), 0);
      check("idle_busy", int'(busy), 0);
      check_results(tbl[i]);
    end

    // abort 20 cycles in, with f_in=1: vectors 0..5 sampled
    mode  = 3;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    check("pre_abort_busy", int'(busy), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_vec", int'({w, x, y, z}), 0);
    seen = int'(done);
    repeat (60) begin
      tick();
      if (done || busy) seen++;
    end
    check("abort_no_done", seen, 0);
    check_results('{m: 3, tt: 16'h003F, cnt: 3, ffi: 1, ffv: 1, ps: 0});

    // restart after abort gives the full golden result
    do_sweep(0, -1);
    check_results(tbl[0]);

    // start re-pulsed mid-sweep is ignored; start in the DONE cycle begins a new sweep at once
    tick();
    do_sweep(1, 10);
    check_results(tbl[1]);
    do_sweep(2, -1);
    check_results(tbl[2]);

    // one-cycle reset mid-sweep
    tick();
    mode  = 3;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    check("pre_rst_tt", int'(truth_table), 16'h0007);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_rst_outs", int'({busy, done, w, x, y, z, pass, first_fail_valid}), 0);
    check("mid_rst_tt", int'(truth_table), 0);
    check("mid_rst_cnt", int'({mismatch_cnt, first_fail_idx}), 0);
    seen = 0;
    repeat (60) begin
      tick();
      if (done || busy) seen++;
    end
    check("mid_rst_no_done", seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
